// File: rtl/roce_rx_write_qp_checker.sv
// roce_rx_write_qp_checker: validates RX RDMA WRITE headers against QP context, then forwards or drops the payload.
module roce_rx_write_qp_checker #(
    parameter int DATA_WIDTH      = 256,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int MAX_QUEUE_PAIRS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_hdr_valid,
    output logic                  s_hdr_ready,
    input  logic [23:0]           s_hdr_dest_qpn,
    input  logic [23:0]           s_hdr_psn,
    input  logic [7:0]            s_hdr_opcode,
    input  logic [31:0]           s_hdr_r_key,
    input  logic [31:0]           s_hdr_immediate_data,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [14:0]           s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [14:0]           m_axis_tuser,
    output logic                  m_qp_context_req,
    output logic [23:0]           m_qp_local_qpn_req,
    input  logic                  s_qp_context_valid,
    input  logic [2:0]            s_qp_state,
    input  logic [31:0]           s_qp_loc_r_key,
    input  logic [23:0]           s_qp_exp_psn,
    output logic                  m_qp_update_valid,
    output logic [23:0]           m_qp_update_loc_qpn,
    output logic [23:0]           m_qp_update_exp_psn,
    output logic                  m_wc_valid,
    output logic [23:0]           m_wc_loc_qpn,
    output logic [31:0]           m_wc_byte_count,
    output logic                  m_wc_has_immediate,
    output logic [31:0]           m_wc_immediate_data,
    output logic                  error_valid,
    output logic [2:0]            error_code,
    output logic [23:0]           error_loc_qpn
);
    localparam int MAX_QUEUE_PAIRS_WIDTH = $clog2(MAX_QUEUE_PAIRS);

    typedef enum logic [1:0] {IDLE, CTX_WAIT, FORWARD, DROP} state_t;

    state_t                  state;
    logic [23:0]             qpn;
    logic [23:0]             psn;
    logic [7:0]              opcode;
    logic [31:0]             r_key;
    logic [31:0]             imm;
    logic [31:0]             byte_cnt;
    logic                    temp_valid;
    logic [DATA_WIDTH-1:0]   temp_tdata;
    logic [KEEP_WIDTH-1:0]   temp_tkeep;
    logic                    temp_tlast;
    logic [14:0]             temp_tuser;

    logic        hdr_fire;
    logic        beat_fire;
    logic        last_fire;
    logic        skid_in;
    logic        fwd_ready;
    logic        qpn_ok;
    logic        need_rkey;
    logic        wc_op;
    logic        imm_op;
    logic [2:0]  ctx_code;
    logic [31:0] beat_bytes;
    logic [31:0] total_bytes;

    assign hdr_fire    = s_hdr_valid && s_hdr_ready;
    assign beat_fire   = s_axis_tvalid && s_axis_tready;
    assign last_fire   = beat_fire && s_axis_tlast;
    assign skid_in     = s_axis_tready && state == FORWARD;
    assign fwd_ready   = m_axis_tready || (!m_axis_tvalid && !temp_valid);
    assign qpn_ok      = s_hdr_dest_qpn[23:8] == 16'd1 && (s_hdr_dest_qpn[7:0] >> MAX_QUEUE_PAIRS_WIDTH) == 8'd0;
    assign need_rkey   = opcode == 8'h06 || opcode == 8'h0A || opcode == 8'h0B;
    assign wc_op       = opcode == 8'h08 || opcode == 8'h09 || opcode == 8'h0A || opcode == 8'h0B;
    assign imm_op      = opcode == 8'h09 || opcode == 8'h0B;
    assign beat_bytes  = 32'($countones(s_axis_tkeep));
    assign total_bytes = byte_cnt + beat_bytes;
    assign ctx_code    = (opcode < 8'h06 || opcode > 8'h0B) ? 3'd2 :
                         (s_qp_state != 3'd2 && s_qp_state != 3'd3) ? 3'd3 :
                         (s_hdr_psn_mismatch(psn, s_qp_exp_psn)) ? 3'd4 :
                         (need_rkey && r_key != s_qp_loc_r_key) ? 3'd5 : 3'd0;

    assign m_qp_local_qpn_req  = qpn;
    assign m_qp_update_loc_qpn = qpn;

    function automatic logic s_hdr_psn_mismatch(input logic [23:0] a, input logic [23:0] b);
        return a != b;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            s_hdr_ready         <= 1'b0;
            s_axis_tready       <= 1'b0;
            m_qp_context_req    <= 1'b0;
            m_qp_update_valid   <= 1'b0;
            m_qp_update_exp_psn <= 24'd0;
            m_wc_valid          <= 1'b0;
            m_wc_loc_qpn        <= 24'd0;
            m_wc_byte_count     <= 32'd0;
            m_wc_has_immediate  <= 1'b0;
            m_wc_immediate_data <= 32'd0;
            error_valid         <= 1'b0;
            error_code          <= 3'd0;
            error_loc_qpn       <= 24'd0;
        end else begin
            m_qp_context_req  <= 1'b0;
            m_qp_update_valid <= 1'b0;
            m_wc_valid        <= 1'b0;
            error_valid       <= 1'b0;
            case (state)
                IDLE: begin
                    s_hdr_ready   <= !hdr_fire;
                    s_axis_tready <= 1'b0;
                    if (hdr_fire) begin
                        qpn    <= s_hdr_dest_qpn;
                        psn    <= s_hdr_psn;
                        opcode <= s_hdr_opcode;
                        r_key  <= s_hdr_r_key;
                        imm    <= s_hdr_immediate_data;
                        if (qpn_ok) begin
                            state            <= CTX_WAIT;
                            m_qp_context_req <= 1'b1;
                        end else begin
                            state         <= DROP;
                            s_axis_tready <= 1'b1;
                            error_valid   <= 1'b1;
                            error_code    <= 3'd1;
                            error_loc_qpn <= s_hdr_dest_qpn;
                        end
                    end
                end
                CTX_WAIT: begin
                    if (s_qp_context_valid) begin
                        if (ctx_code != 3'd0) begin
                            state         <= DROP;
                            s_axis_tready <= 1'b1;
                            error_valid   <= 1'b1;
                            error_code    <= ctx_code;
                            error_loc_qpn <= qpn;
                        end else begin
                            state               <= FORWARD;
                            byte_cnt            <= 32'd0;
                            m_qp_update_valid   <= 1'b1;
                            m_qp_update_exp_psn <= psn + 24'd1;
                        end
                    end
                end
                FORWARD: begin
                    s_axis_tready <= fwd_ready;
                    if (beat_fire) byte_cnt <= total_bytes;
                    if (last_fire) begin
                        state         <= IDLE;
                        s_axis_tready <= 1'b0;
                        s_hdr_ready   <= 1'b1;
                        m_wc_valid    <= wc_op;
                        if (wc_op) begin
                            m_wc_loc_qpn        <= qpn;
                            m_wc_byte_count     <= total_bytes;
                            m_wc_has_immediate  <= imm_op;
                            m_wc_immediate_data <= imm;
                        end
                    end
                end
                DROP: begin
                    if (last_fire) begin
                        state         <= IDLE;
                        s_axis_tready <= 1'b0;
                        s_hdr_ready   <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Skid buffer: s_axis_tready is registered, so one extra beat may land in temp.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            temp_valid    <= 1'b0;
        end else if (skid_in) begin
            if (m_axis_tready || !m_axis_tvalid) begin
                m_axis_tvalid <= s_axis_tvalid;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tkeep  <= s_axis_tkeep;
                m_axis_tlast  <= s_axis_tlast;
                m_axis_tuser  <= s_axis_tuser;
            end else begin
                temp_valid <= s_axis_tvalid;
                temp_tdata <= s_axis_tdata;
                temp_tkeep <= s_axis_tkeep;
                temp_tlast <= s_axis_tlast;
                temp_tuser <= s_axis_tuser;
            end
        end else if (m_axis_tready) begin
            m_axis_tvalid <= temp_valid;
            temp_valid    <= 1'b0;
            m_axis_tdata  <= temp_tdata;
            m_axis_tkeep  <= temp_tkeep;
            m_axis_tlast  <= temp_tlast;
            m_axis_tuser  <= temp_tuser;
        end
    end
endmodule

// File: tb/tb_roce_rx_write_qp_checker.sv
// tb_roce_rx_write_qp_checker: randomized scoreboard bench with a QP-context memory model.
module tb_roce_rx_write_qp_checker;
    localparam int DW = 256;
    localparam int KW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           s_hdr_valid, s_hdr_ready;
    logic [23:0]    s_hdr_dest_qpn, s_hdr_psn;
    logic [7:0]     s_hdr_opcode;
    logic [31:0]    s_hdr_r_key, s_hdr_immediate_data;
    logic [DW-1:0]  s_axis_tdata, m_axis_tdata;
    logic [KW-1:0]  s_axis_tkeep, m_axis_tkeep;
    logic           s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [14:0]    s_axis_tuser, m_axis_tuser;
    logic           m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic           m_qp_context_req;
    logic [23:0]    m_qp_local_qpn_req;
    logic           s_qp_context_valid;
    logic [2:0]     s_qp_state;
    logic [31:0]    s_qp_loc_r_key;
    logic [23:0]    s_qp_exp_psn;
    logic           m_qp_update_valid;
    logic [23:0]    m_qp_update_loc_qpn, m_qp_update_exp_psn;
    logic           m_wc_valid, m_wc_has_immediate;
    logic [23:0]    m_wc_loc_qpn;
    logic [31:0]    m_wc_byte_count, m_wc_immediate_data;
    logic           error_valid;
    logic [2:0]     error_code;
    logic [23:0]    error_loc_qpn;

    roce_rx_write_qp_checker dut (
        .clk(clk), .rst(rst),
        .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
        .s_hdr_dest_qpn(s_hdr_dest_qpn), .s_hdr_psn(s_hdr_psn), .s_hdr_opcode(s_hdr_opcode),
        .s_hdr_r_key(s_hdr_r_key), .s_hdr_immediate_data(s_hdr_immediate_data),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_qp_context_req(m_qp_context_req), .m_qp_local_qpn_req(m_qp_local_qpn_req),
        .s_qp_context_valid(s_qp_context_valid), .s_qp_state(s_qp_state),
        .s_qp_loc_r_key(s_qp_loc_r_key), .s_qp_exp_psn(s_qp_exp_psn),
        .m_qp_update_valid(m_qp_update_valid), .m_qp_update_loc_qpn(m_qp_update_loc_qpn),
        .m_qp_update_exp_psn(m_qp_update_exp_psn),
        .m_wc_valid(m_wc_valid), .m_wc_loc_qpn(m_wc_loc_qpn), .m_wc_byte_count(m_wc_byte_count),
        .m_wc_has_immediate(m_wc_has_immediate), .m_wc_immediate_data(m_wc_immediate_data),
        .error_valid(error_valid), .error_code(error_code), .error_loc_qpn(error_loc_qpn)
    );

    typedef struct packed {logic [DW-1:0] data; logic [KW-1:0] keep; logic [14:0] user; logic last;} beat_t;
    typedef struct packed {logic [23:0] qpn; logic [23:0] psn;} upd_t;
    typedef struct packed {logic [23:0] qpn; logic [31:0] bytes; logic has_imm; logic [31:0] imm;} wc_t;
    typedef struct packed {logic [2:0] code; logic [23:0] qpn;} err_t;

    beat_t       q_beat[$];
    logic [23:0] q_req[$];
    upd_t        q_upd[$];
    wc_t         q_wc[$];
    err_t        q_err[$];

    int errors = 0;
    int checks = 0;
    int tr_mode = 0;

    // Context memory seen by the DUT; PSN advances only after a packet is fully accepted.
    logic [2:0]  qp_state[4];
    logic [31:0] qp_rkey[4];
    logic [23:0] qp_psn[4];

    logic [23:0] r_qpn, r_psn;
    logic [7:0]  r_op;
    logic [31:0] r_rkey;
    logic [1:0]  r_q;

    function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void unexpected(string name, logic [255:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected no output", name, act);
    endfunction

    task automatic timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s: got no handshake expected one within 200 cycles", name);
    endtask

    task automatic check_reset(string tag);
        chk({tag, "_hdr_ready"}, 256'(s_hdr_ready), 256'(0));
        chk({tag, "_s_tready"}, 256'(s_axis_tready), 256'(0));
        chk({tag, "_m_tvalid"}, 256'(m_axis_tvalid), 256'(0));
        chk({tag, "_ctx_req"}, 256'(m_qp_context_req), 256'(0));
        chk({tag, "_upd_valid"}, 256'(m_qp_update_valid), 256'(0));
        chk({tag, "_wc_valid"}, 256'(m_wc_valid), 256'(0));
        chk({tag, "_err_valid"}, 256'(error_valid), 256'(0));
        chk({tag, "_err_code"}, 256'(error_code), 256'(0));
        chk({tag, "_err_qpn"}, 256'(error_loc_qpn), 256'(0));
        chk({tag, "_wc_bytes"}, 256'(m_wc_byte_count), 256'(0));
    endtask

    task automatic send_pkt(input logic [23:0] qpn, input logic [7:0] op, input logic [23:0] psn,
                            input logic [31:0] rkey, input logic [31:0] imm, input int nb,
                            input logic [31:0] lastkeep, input int abort_after);
        beat_t       beats[$];
        beat_t       bt;
        int          code, t, sent;
        logic [31:0] bytes;
        logic [23:0] psn_next;
        logic        qv;
        logic [1:0]  q;
        q     = qpn[1:0];
        qv    = (qpn >> 8) == 24'd1 && qpn[7:0] < 8'd4;
        bytes = 0;
        for (int b = 0; b < nb; b++) begin
            for (int w = 0; w < 8; w++) bt.data[w*32 +: 32] = $urandom;
            bt.keep = (b == nb - 1) ? lastkeep : '1;
            bt.user = 15'($urandom);
            bt.last = (b == nb - 1);
            beats.push_back(bt);
            for (int k = 0; k < KW; k++) bytes += 32'(bt.keep[k]);
        end
        code = 0;
        if (!qv) code = 1;
        else if (op < 8'h06 || op > 8'h0B) code = 2;
        else if (qp_state[q] != 3'd2 && qp_state[q] != 3'd3) code = 3;
        else if (psn != qp_psn[q]) code = 4;
        else if ((op == 8'h06 || op == 8'h0A || op == 8'h0B) && rkey != qp_rkey[q]) code = 5;
        psn_next = 24'((32'(psn) + 32'd1) % 32'h0100_0000);
        if (qv) q_req.push_back(qpn);
        if (code != 0) q_err.push_back('{code: 3'(code), qpn: qpn});
        else begin
            q_upd.push_back('{qpn: qpn, psn: psn_next});
            foreach (beats[b]) q_beat.push_back(beats[b]);
            if (op >= 8'h08 && op <= 8'h0B)
                q_wc.push_back('{qpn: qpn, bytes: bytes, has_imm: (op == 8'h09 || op == 8'h0B), imm: imm});
        end
        @(posedge clk); #1;
        s_hdr_dest_qpn = qpn; s_hdr_psn = psn; s_hdr_opcode = op;
        s_hdr_r_key = rkey; s_hdr_immediate_data = imm; s_hdr_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_hdr_ready && t < 200);
        if (!s_hdr_ready) begin timeout("hdr_handshake"); s_hdr_valid = 1'b0; return; end
        @(posedge clk); #1;
        s_hdr_valid = 1'b0;
        sent = 0;
        foreach (beats[b]) begin
            if (abort_after >= 0 && sent >= abort_after) break;
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast} = beats[b];
            s_axis_tvalid = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!s_axis_tready && t < 200);
            if (!s_axis_tready) begin timeout("payload_accept"); s_axis_tvalid = 1'b0; return; end
            @(posedge clk); #1;
            s_axis_tvalid = 1'b0;
            sent++;
        end
        if (code == 0 && abort_after < 0) qp_psn[q] = psn_next;
    endtask

    // Context responder: answers each query after 0..2 cycles.
    initial begin
        logic [1:0] idx;
        int d;
        s_qp_context_valid = 1'b0;
        s_qp_state = 3'd0; s_qp_loc_r_key = 32'd0; s_qp_exp_psn = 24'd0;
        forever begin
            @(negedge clk);
            if (!rst && m_qp_context_req) begin
                idx = m_qp_local_qpn_req[1:0];
                s_qp_state = qp_state[idx]; s_qp_loc_r_key = qp_rkey[idx]; s_qp_exp_psn = qp_psn[idx];
                d = $urandom_range(0, 2);
                if (d == 0) s_qp_context_valid = 1'b1;
                else begin repeat (d) @(posedge clk); #1; s_qp_context_valid = 1'b1; end
                @(posedge clk); #1;
                s_qp_context_valid = 1'b0;
            end
        end
    end

    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_axis_tready = tr_mode == 0 ? 1'b1 : tr_mode == 1 ? 1'($urandom_range(0, 1)) : !m_axis_tready;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (q_beat.size() == 0) unexpected("beat_unexpected", m_axis_tdata);
                else begin
                    beat_t b;
                    b = q_beat.pop_front();
                    chk("beat_data", m_axis_tdata, b.data);
                    chk("beat_keep", 256'(m_axis_tkeep), 256'(b.keep));
                    chk("beat_user", 256'(m_axis_tuser), 256'(b.user));
                    chk("beat_last", 256'(m_axis_tlast), 256'(b.last));
                end
            end
            if (m_qp_context_req) begin
                if (q_req.size() == 0) unexpected("ctx_req_unexpected", 256'(m_qp_local_qpn_req));
                else chk("ctx_req_qpn", 256'(m_qp_local_qpn_req), 256'(q_req.pop_front()));
            end
            if (m_qp_update_valid) begin
                if (q_upd.size() == 0) unexpected("update_unexpected", 256'(m_qp_update_exp_psn));
                else begin
                    upd_t u;
                    u = q_upd.pop_front();
                    chk("update_qpn", 256'(m_qp_update_loc_qpn), 256'(u.qpn));
                    chk("update_psn", 256'(m_qp_update_exp_psn), 256'(u.psn));
                end
            end
            if (m_wc_valid) begin
                if (q_wc.size() == 0) unexpected("wc_unexpected", 256'(m_wc_byte_count));
                else begin
                    wc_t w;
                    w = q_wc.pop_front();
                    chk("wc_qpn", 256'(m_wc_loc_qpn), 256'(w.qpn));
                    chk("wc_bytes", 256'(m_wc_byte_count), 256'(w.bytes));
                    chk("wc_has_imm", 256'(m_wc_has_immediate), 256'(w.has_imm));
                    chk("wc_imm", 256'(m_wc_immediate_data), 256'(w.imm));
                end
            end
            if (error_valid) begin
                if (q_err.size() == 0) unexpected("error_unexpected", 256'(error_code));
                else begin
                    err_t e;
                    e = q_err.pop_front();
                    chk("error_code", 256'(error_code), 256'(e.code));
                    chk("error_qpn", 256'(error_loc_qpn), 256'(e.qpn));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s_hdr_valid = 1'b0; s_hdr_dest_qpn = '0; s_hdr_psn = '0; s_hdr_opcode = '0;
        s_hdr_r_key = '0; s_hdr_immediate_data = '0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; s_axis_tuser = '0;
        for (int i = 0; i < 4; i++) begin
            qp_state[i] = 3'd3; qp_rkey[i] = $urandom; qp_psn[i] = 24'($urandom);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        qp_psn[1] = 24'h000010; qp_rkey[1] = 32'h1234_5678;
        send_pkt(24'h000101, 8'h0A, 24'h000010, 32'h1234_5678, 32'h0, 3, 32'h0000_FFFF, -1);
        qp_psn[1] = 24'hFFFFFF;
        send_pkt(24'h000101, 8'h06, 24'hFFFFFF, 32'h1234_5678, 32'h0, 2, '1, -1);
        send_pkt(24'h000205, 8'h0A, 24'h0, 32'h0, 32'h0, 4, '1, -1);
        qp_state[2] = 3'd1;
        send_pkt(24'h000102, 8'h0A, qp_psn[2], qp_rkey[2], 32'h0, 2, '1, -1);
        qp_state[2] = 3'd3; qp_psn[2] = 24'h000021;
        send_pkt(24'h000102, 8'h0A, 24'h000020, qp_rkey[2], 32'h0, 2, '1, -1);
        tr_mode = 2; qp_state[3] = 3'd2;
        send_pkt(24'h000103, 8'h0B, qp_psn[3], qp_rkey[3], 32'hDEAD_BEEF, 8, 32'h0000_00FF, -1);
        tr_mode = 0;
        repeat (10) @(posedge clk);

        send_pkt(24'h000100, 8'h07, qp_psn[0], qp_rkey[0], 32'h0, 6, '1, 2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("mid_reset");
        q_beat.delete(); q_wc.delete(); q_req.delete(); q_upd.delete(); q_err.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        send_pkt(24'h000100, 8'h0A, qp_psn[0], qp_rkey[0], 32'h0, 2, 32'h0000_000F, -1);

        for (int i = 0; i < 40; i++) begin
            r_q   = 2'($urandom_range(0, 3));
            r_qpn = ($urandom_range(0, 7) == 0) ? 24'($urandom) : {16'h0001, 6'd0, r_q};
            r_op  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(6, 11));
            qp_state[r_qpn[1:0]] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(2, 3));
            r_psn  = ($urandom_range(0, 5) == 0) ? qp_psn[r_qpn[1:0]] + 24'd1 : qp_psn[r_qpn[1:0]];
            r_rkey = ($urandom_range(0, 5) == 0) ? ~qp_rkey[r_qpn[1:0]] : qp_rkey[r_qpn[1:0]];
            tr_mode = $urandom_range(0, 2);
            send_pkt(r_qpn, r_op, r_psn, r_rkey, $urandom, $urandom_range(1, 4), $urandom, -1);
        end

        tr_mode = 0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("beats_left", 256'(q_beat.size()), 256'(0));
        chk("reqs_left", 256'(q_req.size()), 256'(0));
        chk("updates_left", 256'(q_upd.size()), 256'(0));
        chk("wcs_left", 256'(q_wc.size()), 256'(0));
        chk("errors_left", 256'(q_err.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
